// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, fetch entry layout and fetch FSM states
package fetch_unit_pkg;
    localparam int XLEN = 64;
    localparam int IALIGN_BITS = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [1:0]      err;
    } fetch_entry_t;

    typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_unit_fifo: synchronous FIFO with flush; a push alongside a flush lands as the only entry
module fetch_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    // storage write; after a flush the pointers restart at slot 0
    always_ff @(posedge clk_i)
        if (push_i) mem[flush_i ? '0 : wr_ptr] <= data_i;

    // pointers and occupancy; full+push+pop in one cycle is legal
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= AW'(push_i);
            rd_ptr  <= '0;
            count_o <= CW'(push_i);
        end else begin
            wr_ptr  <= wr_ptr + AW'(push_i);
            rd_ptr  <= rd_ptr + AW'(pop_i);
            count_o <= count_o + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem[rd_ptr];
    assign empty_o = count_o == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing pipelined imem requests, buffering responses for decode, handling redirects
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output logic            if_valid_o,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [1:0]      if_err_o,
    input  logic            id_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, rsp_pc;
    logic [CW-1:0]   outstanding, outstanding_next, drop_cnt, fifo_count, addr_count;
    logic            xfer, keep_rsp, misaligned, entry_push, fifo_empty, addr_empty;
    fetch_entry_t    entry_in, entry_out;

    // next state and request gating: credit counts in-flight requests plus buffered entries
    always_comb begin
        misaligned = redirect_pc_i[IALIGN_BITS-1:0] != '0;
        state_next = redirect_i ? (misaligned ? HALT : RUN) : state;
        imem_req_o = rst_i && !redirect_i && state == RUN &&
                     ({1'b0, outstanding} + {1'b0, fifo_count} < (CW+1)'(FIFO_DEPTH));
    end

    assign xfer             = imem_req_o && imem_gnt_i;
    assign keep_rsp         = imem_rvalid_i && drop_cnt == '0 && !redirect_i;
    assign outstanding_next = outstanding + CW'(xfer) - CW'(imem_rvalid_i);
    assign entry_push       = redirect_i ? misaligned : keep_rsp;
    assign entry_in         = redirect_i ? fetch_entry_t'{NOP_INSTR, redirect_pc_i, 2'b10}
                                         : fetch_entry_t'{imem_rdata_i, rsp_pc, {1'b0, imem_err_i}};
    assign imem_addr_o      = pc;
    assign if_valid_o       = rst_i && !fifo_empty && !redirect_i;
    assign {if_instr_o, if_pc_o, if_err_o} = entry_out;

    // FSM state register
    always_ff @(posedge clk_i)
        state <= !rst_i ? RUN : state_next;

    // PC, in-flight count, and count of wrong-path responses still to discard
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            pc          <= redirect_i ? redirect_pc_i : (xfer ? pc + XLEN'(4) : pc);
            outstanding <= outstanding_next;
            drop_cnt    <= redirect_i ? outstanding_next
                                      : (imem_rvalid_i && drop_cnt != '0 ? drop_cnt - 1'b1 : drop_cnt);
        end
    end

    // every response must match a request; kept responses must find their PC queued
    always_ff @(posedge clk_i) begin
        if (rst_i && imem_rvalid_i) assert (outstanding != '0 && (drop_cnt != '0 || !addr_empty));
        if (rst_i) assert (addr_count <= CW'(FIFO_DEPTH));
    end

    fetch_unit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_entry_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (entry_push),
        .pop_i   (if_valid_o && id_ready_i),
        .data_i  (entry_in),
        .data_o  (entry_out),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    fetch_unit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_addr_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (xfer),
        .pop_i   (keep_rsp),
        .data_i  (pc),
        .data_o  (rsp_pc),
        .empty_o (addr_empty),
        .count_o (addr_count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with an in-order imem responder and directed fetch scenarios
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int              DEPTH    = 4;
    localparam logic [XLEN-1:0] ERR_ADDR = 64'h8;

    logic            clk = 1'b0;
    logic            rst, redirect, imem_req, imem_gnt, imem_rvalid, imem_err;
    logic            if_valid, id_ready;
    logic [XLEN-1:0] redirect_pc, imem_addr, if_pc;
    logic [31:0]     imem_rdata, if_instr;
    logic [1:0]      if_err;

    int              checks = 0, errors = 0, grants = 0, pops = 0, mark;
    bit              resp_en;
    logic [XLEN-1:0] exp_pc, rsp_addr;
    fetch_entry_t    exp_q[$], got;
    logic [XLEN-1:0] pend[$];

    fetch_unit #(.RESET_PC('0), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .imem_err_i    (imem_err),
        .if_valid_o    (if_valid),
        .if_instr_o    (if_instr),
        .if_pc_o       (if_pc),
        .if_err_o      (if_err),
        .id_ready_i    (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'h5A00_0000;
    endfunction

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one-cycle redirect; the scoreboard forgets all wrong-path expectations
    task automatic do_redirect(input logic [XLEN-1:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        exp_q.delete();
        exp_pc = target;
        if (target[1:0] != 2'b00) exp_q.push_back(fetch_entry_t'{NOP_INSTR, target, 2'b10});
        #1;
        check(!imem_req, "redirect_req", imem_req, 0);
        check(!if_valid, "redirect_valid", if_valid, 0);
        tick(1);
        redirect = 1'b0;
    endtask

    task automatic drain();
        imem_gnt = 1'b0;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || pend.size() != 0); i++) tick(1);
        tick(3);
        check(exp_q.size() == 0, "drain_left", exp_q.size(), 0);
    endtask

    // monitor pops and compares delivered entries; grant capture issues expectations
    always @(negedge clk) begin
        if (rst && if_valid && id_ready) begin
            pops++;
            check(exp_q.size() != 0, "entry_expected", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check({if_instr, if_pc, if_err} == got, "entry", {if_instr, if_pc, if_err}, got);
            end
        end
        if (rst && imem_req && imem_gnt) begin
            check(imem_addr == exp_pc, "imem_addr", imem_addr, exp_pc);
            pend.push_back(imem_addr);
            exp_q.push_back(fetch_entry_t'{word(exp_pc), exp_pc, {1'b0, exp_pc == ERR_ADDR}});
            exp_pc += 4;
            grants++;
        end
    end

    // in-order memory: answers each grant one cycle later while enabled
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_err    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && pend.size() != 0) begin
                rsp_addr    = pend.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = word(rsp_addr);
                imem_err    = rsp_addr == ERR_ADDR;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
                imem_err    = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        id_ready = 1'b1; resp_en = 1'b1; exp_pc = '0;
        tick(3);
        check(!imem_req, "reset_req", imem_req, 0);
        check(!if_valid, "reset_valid", if_valid, 0);

        // streaming from reset: one instruction per cycle, bus error on 0x8
        rst = 1'b1; imem_gnt = 1'b1;
        tick(6);
        mark = pops;
        tick(10);
        check(pops - mark == 10, "throughput", pops - mark, 10);
        drain();

        // decode stalled: only DEPTH requests may be granted
        id_ready = 1'b0; imem_gnt = 1'b1;
        mark = grants;
        tick(10);
        check(grants - mark == DEPTH, "credit_grants", grants - mark, DEPTH);
        check(!imem_req, "credit_req", imem_req, 0);
        check(if_valid, "stall_valid", if_valid, 1);
        id_ready = 1'b1;
        tick(10);
        drain();

        // two in flight then redirect: both responses dropped
        resp_en = 1'b0; imem_gnt = 1'b1;
        tick(2);
        imem_gnt = 1'b0;
        tick(1);
        check(pend.size() == 2, "inflight", pend.size(), 2);
        do_redirect(64'h100);
        resp_en = 1'b1; imem_gnt = 1'b1;
        tick(12);
        drain();

        // back-to-back redirects while drops pending must not accumulate
        resp_en = 1'b0; imem_gnt = 1'b1;
        tick(2);
        imem_gnt = 1'b0;
        tick(1);
        do_redirect(64'h180);
        do_redirect(64'h1C0);
        resp_en = 1'b1; imem_gnt = 1'b1;
        tick(12);
        drain();

        // redirect coinciding with rvalid and gnt in steady streaming
        imem_gnt = 1'b1;
        tick(6);
        do_redirect(64'h200);
        tick(10);
        drain();

        // misaligned target: NOP entry with misaligned flag, then idle until redirect
        imem_gnt = 1'b1;
        tick(6);
        do_redirect(64'h102);
        mark = grants;
        tick(8);
        check(grants == mark, "halt_grants", grants - mark, 0);
        check(!imem_req, "halt_req", imem_req, 0);
        drain();
        do_redirect(64'h300);
        imem_gnt = 1'b1;
        tick(8);

        // reset mid-burst: outputs quiet, fetch restarts at RESET_PC
        rst = 1'b0;
        pend.delete();
        exp_q.delete();
        exp_pc = '0;
        tick(1);
        check(!imem_req, "midreset_req", imem_req, 0);
        check(!if_valid, "midreset_valid", if_valid, 0);
        tick(1);
        rst = 1'b1;
        tick(10);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
